game_session_ctrl: RTL and testbench
====================================

# game_session_ctrl

Session controller on the opposite side of the countdown timer interface. It drives the timer's restart input and consumes its `seconds`/`game_over` outputs. It sequences idle, playing and game-over phases, keeps the hit score, and converts remaining seconds to BCD for the display mux.

## Interface
- `BLINK_PERIOD`, 50_000_000: cycles per blink half-period in OVER (bench uses 5000).
- `SCORE_W`, 8: score register width.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_start_btn`  in  1  debounced start button level; a rising edge is a start request.
- `i_hit`  in  1  one-cycle pulse per successful mole hit.
- `i_seconds`  in  5  remaining seconds from the timer (0–31 legal).
- `i_game_over`  in  1  timer expiry flag, level.
- `o_restart_game`  out  1  to the timer restart input; high holds the timer at its start value.
- `o_playing`  out  1  high only in PLAYING.
- `o_score`  out  SCORE_W  hits in the current or last session.
- `o_high_score`  out  SCORE_W  best completed-session score.
- `o_sec_tens`  out  4  BCD tens of `i_seconds`.
- `o_sec_ones`  out  4  BCD ones of `i_seconds`.
- `o_blink`  out  1  blink phase, active in OVER only.

## Operation
- Start edge: `start_edge = i_start_btn & ~btn_q`. `btn_q` resets to 1, so a button held through reset does not start a game.
- States are IDLE, RESTART, PLAYING and OVER. Reset enters IDLE.
- IDLE:
  - `o_restart_game`=1 (timer frozen).
  - `start_edge` → RESTART.
- RESTART (exactly 1 cycle):
  - `o_restart_game`=1.
  - Score cleared to 0.
  - Blink counter and `o_blink` cleared.
  - → PLAYING.
- PLAYING:
  - `o_restart_game`=0.
  - `i_hit` increments score, saturating at 2^SCORE_W−1.
  - `i_game_over`=1 → OVER. A hit in the same cycle is still counted.
  - `start_edge` is ignored.
- OVER:
  - Score frozen; `i_hit` ignored.
  - Blink counter counts 0..BLINK_PERIOD−1, then `o_blink` toggles and the counter wraps.
  - `start_edge` → RESTART.
- `o_restart_game` and `o_playing` are decoded from the state register (Moore), not from inputs.
- BCD conversion:
  - Registered each cycle in every state: tens = `i_seconds`/10, ones = `i_seconds`%10.
  - Example: 31 → 3/1; 0 → 0/0.
- `rst` mid-session aborts immediately:
  - Next cycle: IDLE, score 0.
  - High score also cleared.

## Timing
- Reset values:
  - state IDLE
  - `o_restart_game`=1, `o_playing`=0
  - `o_score`=0, `o_high_score`=0
  - `o_sec_tens`=0, `o_sec_ones`=0
  - `o_blink`=0
- Start latency: with `start_edge` sampled at edge n:
  - RESTART during n..n+1.
  - PLAYING and `o_playing`=1 from edge n+1.
  - `o_restart_game` falls at edge n+2.
- Hit sampled at edge n → `o_score` updated after edge n.
- `i_game_over` sampled at edge n → OVER and `o_playing`=0 after edge n.
- First `o_blink` toggle happens BLINK_PERIOD cycles after entering OVER.
- BCD outputs lag `i_seconds` by 1 cycle.

## Configuration
- `HIGH_SCORE_EN` defined:
  - On the cycle PLAYING→OVER, `o_high_score` ← final score if it is strictly greater (final score includes a same-cycle hit).
  - Retained across sessions; cleared only by `rst`.
- Undefined: `o_high_score` is tied to 0 and no comparison logic is built.

## Test plan
- Reset with `i_start_btn` held 1, release, press again → no start until the second rising edge. Then RESTART for 1 cycle, `o_playing`=1, `o_restart_game`=0 one cycle later.
- PLAYING, 5 `i_hit` pulses, then `i_game_over`=1 with a hit in the same cycle → `o_score`=6, OVER, `o_playing`=0. With `HIGH_SCORE_EN`, `o_high_score`=6.
- OVER with BLINK_PERIOD=4 → `o_blink` toggles every 4 cycles. Hits ignored; score stays 6.
- Start in OVER → score 0 after RESTART. Second game ends with 3 → `o_high_score` stays 6; a third game ending with 9 → 9.
- SCORE_W=2, 5 hits → `o_score` saturates at 3.
- `i_seconds` sweep 0..31 → BCD matches one cycle later (29 → 2/9, 10 → 1/0). `rst` mid-PLAYING → IDLE, `o_restart_game`=1, score 0.

Source files
------------

// File: rtl/game_session_ctrl_if.sv
// Signal bundle between the session controller and its surroundings:
// button/hit/timer inputs in, restart/score/BCD/blink outputs out.
interface game_session_ctrl_if #(
   parameter int SCORE_W = 8
);
   logic               i_start_btn;
   logic               i_hit;
   logic [4:0]         i_seconds;
   logic               i_game_over;
   logic               o_restart_game;
   logic               o_playing;
   logic [SCORE_W-1:0] o_score;
   logic [SCORE_W-1:0] o_high_score;
   logic [3:0]         o_sec_tens;
   logic [3:0]         o_sec_ones;
   logic               o_blink;

   modport master (
      output i_start_btn, i_hit, i_seconds, i_game_over,
      input  o_restart_game, o_playing, o_score, o_high_score,
      input  o_sec_tens, o_sec_ones, o_blink
   );

   modport slave (
      input  i_start_btn, i_hit, i_seconds, i_game_over,
      output o_restart_game, o_playing, o_score, o_high_score,
      output o_sec_tens, o_sec_ones, o_blink
   );
endinterface

// File: rtl/game_session_ctrl.sv
// Game session sequencer: IDLE/RESTART/PLAYING/OVER, hit score, seconds-to-BCD, blink.
// Define HIGH_SCORE_EN to build the best-session high-score register.
module game_session_ctrl #(
   parameter int BLINK_PERIOD = 50_000_000,
   parameter int SCORE_W      = 8
) (
   input  logic                clk,
   input  logic                rst,
   game_session_ctrl_if.slave  bus
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RESTART = 2'd1;
   localparam logic [1:0] ST_PLAYING = 2'd2;
   localparam logic [1:0] ST_OVER    = 2'd3;

   localparam int                 CNT_W     = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BLINK_PERIOD - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   logic [1:0]         state_q, state_d;
   logic               btn_q, btn_d;
   logic               restart_q, restart_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               blink_q, blink_d;
   logic [3:0]         tens_q, tens_d;
   logic [3:0]         ones_q, ones_d;
   logic               start_edge;

   always_comb begin
      start_edge = bus.i_start_btn & ~btn_q;
      btn_d      = bus.i_start_btn;
      state_d    = state_q;
      score_d    = score_q;
      cnt_d      = cnt_q;
      blink_d    = blink_q;
      // Registered state decode: restart drops one cycle after PLAYING is entered.
      restart_d  = (state_q != ST_PLAYING);
      case (state_q)
         ST_IDLE: begin
            if (start_edge) state_d = ST_RESTART;
         end
         ST_RESTART: begin
            score_d = '0;
            cnt_d   = '0;
            blink_d = 1'b0;
            state_d = ST_PLAYING;
         end
         ST_PLAYING: begin
            if (bus.i_hit && (score_q != SCORE_MAX)) score_d = score_q + 1'b1;
            if (bus.i_game_over) state_d = ST_OVER;
         end
         ST_OVER: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               blink_d = ~blink_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            if (start_edge) state_d = ST_RESTART;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      if (bus.i_seconds >= 5'd30) begin
         tens_d = 4'd3;
         ones_d = 4'(bus.i_seconds - 5'd30);
      end else if (bus.i_seconds >= 5'd20) begin
         tens_d = 4'd2;
         ones_d = 4'(bus.i_seconds - 5'd20);
      end else if (bus.i_seconds >= 5'd10) begin
         tens_d = 4'd1;
         ones_d = 4'(bus.i_seconds - 5'd10);
      end else begin
         tens_d = 4'd0;
         ones_d = 4'(bus.i_seconds);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         btn_q     <= 1'b1;
         restart_q <= 1'b1;
         score_q   <= '0;
         cnt_q     <= '0;
         blink_q   <= 1'b0;
         tens_q    <= 4'd0;
         ones_q    <= 4'd0;
      end else begin
         state_q   <= state_d;
         btn_q     <= btn_d;
         restart_q <= restart_d;
         score_q   <= score_d;
         cnt_q     <= cnt_d;
         blink_q   <= blink_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
      end
   end

`ifdef HIGH_SCORE_EN
   logic [SCORE_W-1:0] high_q, high_d;

   // score_d already includes a hit landing in the final PLAYING cycle.
   always_comb begin
      high_d = high_q;
      if ((state_q == ST_PLAYING) && bus.i_game_over && (score_d > high_q)) high_d = score_d;
   end

   always_ff @(posedge clk) begin
      if (rst) high_q <= '0;
      else     high_q <= high_d;
   end

   assign bus.o_high_score = high_q;
`else
   assign bus.o_high_score = '0;
`endif

   assign bus.o_restart_game = restart_q;
   assign bus.o_playing      = (state_q == ST_PLAYING);
   assign bus.o_score        = score_q;
   assign bus.o_sec_tens     = tens_q;
   assign bus.o_sec_ones     = ones_q;
   assign bus.o_blink        = blink_q;
endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl with a score/BCD expectation queue.
module tb_game_session_ctrl;
   localparam int BP = 5000;
   localparam int SW = 8;
   localparam int SMAX = (1 << SW) - 1;
`ifdef HIGH_SCORE_EN
   localparam bit HS_EN = 1'b1;
`else
   localparam bit HS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   failed = 0;
   int   sc = 0;
   int   hs = 0;
   int   exp_q[$];

   game_session_ctrl_if #(.SCORE_W(SW)) bus ();

   game_session_ctrl #(.BLINK_PERIOD(BP), .SCORE_W(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic pop_check(input string tag, input int obs);
      if (exp_q.size() == 0) begin
         tests++;
         failed++;
         $error("FAIL %s observed=%0d expected=<empty queue>", tag, obs);
      end else begin
         check(tag, obs, exp_q.pop_front());
      end
   endtask

   function automatic int exp_hs();
      return HS_EN ? hs : 0;
   endfunction

   task automatic play_hits(input int n);
      for (int i = 0; i < n; i++) begin
         bus.i_hit = 1'b1;
         sc = (sc < SMAX) ? sc + 1 : SMAX;
         exp_q.push_back(sc);
         tick();
         pop_check("score_hit", int'(bus.o_score));
      end
      bus.i_hit = 1'b0;
   endtask

   task automatic end_game();
      bus.i_game_over = 1'b1;
      tick();
      if (sc > hs) hs = sc;
      check("over_playing", int'(bus.o_playing), 0);
      check("over_score", int'(bus.o_score), sc);
      check("high_score", int'(bus.o_high_score), exp_hs());
   endtask

   task automatic start_game();
      bus.i_start_btn = 1'b0;
      tick();
      bus.i_game_over = 1'b0;
      bus.i_start_btn = 1'b1;
      tick();
      tick();
      sc = 0;
      check("start_score", int'(bus.o_score), 0);
      check("start_blink", int'(bus.o_blink), 0);
      check("start_playing", int'(bus.o_playing), 1);
   endtask

   initial begin
      bus.i_start_btn = 1'b1;
      bus.i_hit       = 1'b0;
      bus.i_seconds   = 5'd0;
      bus.i_game_over = 1'b0;
      tick();
      tick();
      check("rst_restart", int'(bus.o_restart_game), 1);
      check("rst_playing", int'(bus.o_playing), 0);
      check("rst_score", int'(bus.o_score), 0);
      check("rst_high", int'(bus.o_high_score), 0);
      check("rst_tens", int'(bus.o_sec_tens), 0);
      check("rst_ones", int'(bus.o_sec_ones), 0);
      check("rst_blink", int'(bus.o_blink), 0);

      // Button held through reset must not start a game.
      rst = 1'b0;
      repeat (3) tick();
      check("held_no_start", int'(bus.o_playing), 0);
      bus.i_start_btn = 1'b0;
      tick();
      check("release_no_start", int'(bus.o_playing), 0);
      bus.i_start_btn = 1'b1;
      tick();
      check("restart_playing", int'(bus.o_playing), 0);
      check("restart_restart", int'(bus.o_restart_game), 1);
      tick();
      check("play_playing", int'(bus.o_playing), 1);
      check("play_restart_still", int'(bus.o_restart_game), 1);
      tick();
      check("play_restart_low", int'(bus.o_restart_game), 0);
      check("play_score0", int'(bus.o_score), 0);

      // Five hits with a start edge buried in them, then a final hit with game_over.
      play_hits(2);
      bus.i_start_btn = 1'b0;
      play_hits(1);
      bus.i_start_btn = 1'b1;
      play_hits(2);
      check("start_ignored", int'(bus.o_playing), 1);
      bus.i_hit = 1'b1;
      sc = sc + 1;
      exp_q.push_back(sc);
      end_game();
      bus.i_hit = 1'b0;
      pop_check("final_hit_score", int'(bus.o_score));
      check("score_six", int'(bus.o_score), 6);
      check("high_six", int'(bus.o_high_score), HS_EN ? 6 : 0);

      // Blink phase in OVER, with hits that must be ignored.
      check("blink_enter", int'(bus.o_blink), 0);
      bus.i_hit = 1'b1;
      repeat (BP - 1) tick();
      check("blink_before_1st", int'(bus.o_blink), 0);
      tick();
      check("blink_1st", int'(bus.o_blink), 1);
      repeat (BP - 1) tick();
      check("blink_before_2nd", int'(bus.o_blink), 1);
      tick();
      check("blink_2nd", int'(bus.o_blink), 0);
      bus.i_hit = 1'b0;
      check("over_hits_ignored", int'(bus.o_score), 6);
      check("over_restart", int'(bus.o_restart_game), 1);

      // Lower second game, higher third game.
      start_game();
      play_hits(3);
      end_game();
      check("high_kept", int'(bus.o_high_score), HS_EN ? 6 : 0);
      start_game();
      play_hits(9);
      end_game();
      check("high_nine", int'(bus.o_high_score), HS_EN ? 9 : 0);

      // Saturation, BCD sweep, then reset mid-PLAYING.
      start_game();
      play_hits(SMAX + 5);
      check("score_saturated", int'(bus.o_score), SMAX);
      for (int s = 0; s < 32; s++) begin
         bus.i_seconds = 5'(s);
         exp_q.push_back(((s / 10) << 4) | (s % 10));
         tick();
         pop_check("bcd", int'({bus.o_sec_tens, bus.o_sec_ones}));
      end
      check("sweep_playing", int'(bus.o_playing), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_playing", int'(bus.o_playing), 0);
      check("abort_restart", int'(bus.o_restart_game), 1);
      check("abort_score", int'(bus.o_score), 0);
      check("abort_high", int'(bus.o_high_score), 0);
      tick();
      check("abort_idle", int'(bus.o_playing), 0);
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
